pc_ir: RTL and testbench
========================

PC_IR -- requirements
Module: pc_ir

Interface
REQ-001 Parameter RESET_PC, 16'h0000: PC value loaded on reset.
REQ-002 Port clk  input  1: single clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-004 Port ps_in  input  2: PC select from control unit: 00 hold, 01 increment, 10 branch, 11 jump.
REQ-005 Port il_in  input  1: instruction load enable from control unit.
REQ-006 Port imem_data_in  input  16: instruction word read combinationally from instruction memory at pc_out.
REQ-007 Port a_in  input  16: register-file A-bus value, the jump target.
REQ-008 Port icount_clr_in  input  1: synchronous clear of the fetch counter.
REQ-009 Port pc_out  output  16: current PC, the instruction memory address.
REQ-010 Port ir_out  output  16: instruction register contents, driving the control unit's ins_in.
REQ-011 Port ir_valid_out  output  1: high once at least one instruction has been loaded since reset.
REQ-012 Port icount_out  output  32: number of fetches (il_in cycles) since reset or clear.

Function
REQ-013 pc_out, ir_out, ir_valid_out and icount_out SHALL be driven directly from registers, with no combinational path from any input.
REQ-014 When ps_in=00, PC SHALL hold its value.
REQ-015 When ps_in=01, PC SHALL take PC+1 modulo 2^16: 16'hFFFF wraps to 16'h0000.
REQ-016 When ps_in=10, PC SHALL take PC + sext16({ir_out[8:6], ir_out[2:0]}) modulo 2^16.
- The 6-bit two's-complement offset spans -32..+31.
- The offset is taken from the currently held IR, not from imem_data_in.
REQ-017 When ps_in=11, PC SHALL take a_in.
REQ-018 When il_in=1, IR SHALL load imem_data_in on the same edge, i.e. the word addressed by the pre-update pc_out.
- ir_valid_out SHALL go to 1 and stay 1 until reset.
REQ-019 When il_in=0, IR SHALL hold its value.
REQ-020 Simultaneous il_in=1 and ps_in≠00 SHALL apply both updates in the same cycle.
- IR gets the old-PC word.
- A branch offset uses the old IR.
REQ-021 icount SHALL increment by 1 on each edge where il_in=1, wrapping 32'hFFFFFFFF→0 with no saturation.
REQ-022 icount_clr_in=1 SHALL set icount to 0 on that edge, with priority over a simultaneous increment.
REQ-023 PC update, IR load and counter update SHALL be independent; latency of every update is one clock edge.

Reset
REQ-024 While rst_n=0, the block SHALL asynchronously force:
- PC = RESET_PC
- IR = 16'h0000
- ir_valid_out = 0
- icount = 0
REQ-025 Reset asserted mid-operation SHALL abort any pending update; the first edge after rst_n rises SHALL behave per REQ-014..REQ-022 using current inputs.

Structure
REQ-026 The PC-select encoding SHALL be an enum pc_sel_t (PS_HOLD, PS_INC, PS_BRANCH, PS_JUMP) in mycpu_pkg, with the control unit and pc_ir sharing it.
REQ-027 Constants PC_W=16, IR_W=16 and ICNT_W=32 SHALL live in mycpu_pkg.
REQ-028 The block SHALL be a single module with no sub-module.
- PC next-state mux, branch adder and counter are inline sequential logic.

Verification
REQ-029 Reset: rst_n=0 asynchronously, no clock edge -> pc_out=0000, ir_out=0000, ir_valid_out=0, icount_out=0.
REQ-030 Fetch/increment sequence, imem returns 16'h1234 at PC 0:
- il_in=1, ps_in=00 for one edge -> ir_out=1234, pc_out=0000, icount_out=1.
- Then ps_in=01 for one edge -> pc_out=0001.
REQ-031 Branch negative, PC=0010, IR with [8:6]=111 and [2:0]=110 (offset -2), ps_in=10 -> pc_out=000E.
- Branch positive with offset +31 from PC=FFF0 -> pc_out=000F (wrap).
REQ-032 Jump: a_in=BEEF, ps_in=11 -> pc_out=BEEF; the same edge with il_in=1 loads IR from the old PC.
REQ-033 PC wrap and counter clear:
- PC=FFFF, ps_in=01 -> pc_out=0000.
- icount_clr_in=1 together with il_in=1 -> icount_out=0.
- Counter preset path 32'hFFFFFFFF plus one fetch -> 0.
REQ-034 Mid-run reset: rst_n pulsed low between edges during a fetch/branch sequence -> all outputs return to reset values immediately; execution restarts at RESET_PC.

Source files
------------

// File: rtl/mycpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mycpu_pkg
// Description : Shared CPU definitions. Holds the datapath widths, the PC-select
//               encoding used by both the control unit and pc_ir, and a
//               helper that extracts the sign-extended branch offset from an
//               instruction word.
// Revision    : 1.0 - initial release
// ============================================================================
package mycpu_pkg;

  localparam int PC_W   = 16;
  localparam int IR_W   = 16;
  localparam int ICNT_W = 32;

  // PC next-state select driven by the control unit.
  typedef enum logic [1:0] {
    PS_HOLD   = 2'b00,
    PS_INC    = 2'b01,
    PS_BRANCH = 2'b10,
    PS_JUMP   = 2'b11
  } pc_sel_t;

  // Branch offset is the 6-bit two's-complement field {ir[8:6], ir[2:0]},
  // sign-extended to PC width (range -32..+31).
  function automatic logic [PC_W-1:0] branch_offset(input logic [IR_W-1:0] ir);
    return {{(PC_W-6){ir[8]}}, ir[8:6], ir[2:0]};
  endfunction

endpackage : mycpu_pkg
`default_nettype wire

// File: rtl/pc_ir.sv
`default_nettype none
// ============================================================================
// Module      : pc_ir
// Description : Program counter, instruction register and fetch counter.
//               PC update, IR load and fetch counting are independent and
//               each takes effect on the next rising clock edge. All outputs
//               come straight from registers.
// Ports       : clk            - clock, rising edge active
//               rst_n          - asynchronous active-low reset
//               ps_in          - PC select (hold / increment / branch / jump)
//               il_in          - instruction load enable
//               imem_data_in   - instruction word at pc_out
//               a_in           - A-bus value, jump target
//               icount_clr_in  - synchronous fetch-counter clear
//               pc_out         - current PC / instruction memory address
//               ir_out         - instruction register
//               ir_valid_out   - an instruction has been loaded since reset
//               icount_out     - fetch count since reset or clear
// Revision    : 1.0 - initial release
// ============================================================================
module pc_ir
  import mycpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        ps_in,
  input  logic              il_in,
  input  logic [IR_W-1:0]   imem_data_in,
  input  logic [PC_W-1:0]   a_in,
  input  logic              icount_clr_in,
  output logic [PC_W-1:0]   pc_out,
  output logic [IR_W-1:0]   ir_out,
  output logic              ir_valid_out,
  output logic [ICNT_W-1:0] icount_out
);

  pc_sel_t           w_sel;
  logic [PC_W-1:0]   r_pc;
  logic [IR_W-1:0]   r_ir;
  logic              r_ir_valid;
  logic [ICNT_W-1:0] r_icount;

  assign w_sel = pc_sel_t'(ps_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
      r_icount   <= '0;
    end else begin
      // Branch offset comes from the IR currently held, so a simultaneous
      // instruction load does not affect the branch target this edge.
      unique case (w_sel)
        PS_HOLD:   r_pc <= r_pc;
        PS_INC:    r_pc <= r_pc + 1'b1;
        PS_BRANCH: r_pc <= r_pc + branch_offset(r_ir);
        PS_JUMP:   r_pc <= a_in;
        default:   r_pc <= r_pc;
      endcase

      if (il_in) begin
        r_ir       <= imem_data_in;
        r_ir_valid <= 1'b1;
      end

      // Clear wins over a simultaneous fetch; the counter wraps freely.
      if (icount_clr_in) begin
        r_icount <= '0;
      end else if (il_in) begin
        r_icount <= r_icount + 1'b1;
      end
    end
  end

  assign pc_out       = r_pc;
  assign ir_out       = r_ir;
  assign ir_valid_out = r_ir_valid;
  assign icount_out   = r_icount;

endmodule : pc_ir
`default_nettype wire

// File: tb/tb_pc_ir.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_ir
// Description : Self-checking bench for pc_ir. A reference model computes the
//               expected register state for each driven cycle and pushes it
//               into a scoreboard queue; each test pops and compares after
//               the clock edge. Spot checks against fixed values cover the
//               specific scenarios (branch +/-, wrap, jump, clears, resets).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_ir;
  import mycpu_pkg::*;

  localparam logic [15:0] RST_PC = 16'h0000;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ir;
    logic        v;
    logic [31:0] cnt;
  } st_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  ps_in = 2'b00;
  logic        il_in = 1'b0;
  logic [15:0] a_in = 16'h0000;
  logic        icount_clr_in = 1'b0;
  logic [15:0] imem_data_in;
  logic [15:0] pc_out;
  logic [15:0] ir_out;
  logic        ir_valid_out;
  logic [31:0] icount_out;

  logic [15:0] mem [0:65535];
  st_t         sb[$];
  st_t         m;
  st_t         e;
  st_t         got;
  int          total = 0;
  int          bad = 0;

  pc_ir #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ps_in         (ps_in),
    .il_in         (il_in),
    .imem_data_in  (imem_data_in),
    .a_in          (a_in),
    .icount_clr_in (icount_clr_in),
    .pc_out        (pc_out),
    .ir_out        (ir_out),
    .ir_valid_out  (ir_valid_out),
    .icount_out    (icount_out)
  );

  always #5 clk = ~clk;

  // Combinational instruction memory read at the current PC.
  assign imem_data_in = mem[pc_out];
  assign got = '{pc: pc_out, ir: ir_out, v: ir_valid_out, cnt: icount_out};

  function automatic logic [15:0] pat(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'hC35A;
  endfunction

  // Drive one cycle of inputs at the falling edge and push the model's
  // expected post-edge state.
  task automatic drive(input logic [1:0] ps, input logic il,
                       input logic [15:0] a, input logic clr);
    st_t n;
    @(negedge clk);
    ps_in = ps; il_in = il; a_in = a; icount_clr_in = clr;
    n = m;
    case (ps)
      2'b01:   n.pc = m.pc + 16'd1;
      2'b10:   n.pc = m.pc + {{10{m.ir[8]}}, m.ir[8:6], m.ir[2:0]};
      2'b11:   n.pc = a;
      default: n.pc = m.pc;
    endcase
    if (il) begin
      n.ir = mem[m.pc];
      n.v  = 1'b1;
    end
    if (clr)     n.cnt = 32'd0;
    else if (il) n.cnt = m.cnt + 32'd1;
    m = n;
    sb.push_back(n);
  endtask

  task automatic reset_model();
    m = '{pc: RST_PC, ir: 16'h0000, v: 1'b0, cnt: 32'd0};
    sb.delete();
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (got !== st_t'({RST_PC, 16'h0000, 1'b0, 32'd0})) begin
      bad++;
      $display("FAIL reset_async: got pc=%h ir=%h v=%b cnt=%h want pc=%h ir=0000 v=0 cnt=0",
               pc_out, ir_out, ir_valid_out, icount_out, RST_PC);
    end
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fetch();
    drive(2'b00, 1'b1, 16'h0000, 1'b0);
    @(posedge clk); #1;
    e = sb.pop_front();
    total++;
    if (got !== e) begin
      bad++; $display("FAIL fetch_sb: got %h want %h", got, e);
    end
    total++;
    if ({ir_out, pc_out, icount_out} !== {16'h1234, 16'h0000, 32'd1}) begin
      bad++; $display("FAIL fetch_load: got ir=%h pc=%h cnt=%h want ir=1234 pc=0000 cnt=1",
                      ir_out, pc_out, icount_out);
    end
    drive(2'b01, 1'b0, 16'h0000, 1'b0);
    @(posedge clk); #1;
    e = sb.pop_front();
    total++;
    if (pc_out !== 16'h0001 || got !== e) begin
      bad++; $display("FAIL fetch_inc: got %h want %h (pc 0001)", got, e);
    end
  endtask

  task automatic test_branch();
    // Negative offset -2 from 0010, then +31 from FFF0 wrapping to 000F.
    logic [1:0]  ps  [6] = '{2'b11, 2'b00, 2'b10, 2'b11, 2'b00, 2'b10};
    logic        il  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] tgt [6] = '{16'h0010, 16'h0, 16'h0, 16'hFFF0, 16'h0, 16'h0};
    for (int i = 0; i < 6; i++) begin
      drive(ps[i], il[i], tgt[i], 1'b0);
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (got !== e) begin
        bad++; $display("FAIL branch_sb[%0d]: got %h want %h", i, got, e);
      end
      if (i == 2) begin
        total++;
        if (pc_out !== 16'h000E) begin
          bad++; $display("FAIL branch_neg: got pc=%h want 000E", pc_out);
        end
      end
      if (i == 5) begin
        total++;
        if (pc_out !== 16'h000F) begin
          bad++; $display("FAIL branch_pos_wrap: got pc=%h want 000F", pc_out);
        end
      end
    end
  endtask

  task automatic test_jump();
    logic [15:0] old_pc;
    old_pc = m.pc;
    drive(2'b11, 1'b1, 16'hBEEF, 1'b0);
    @(posedge clk); #1;
    e = sb.pop_front();
    total++;
    if (got !== e) begin
      bad++; $display("FAIL jump_sb: got %h want %h", got, e);
    end
    total++;
    if ({pc_out, ir_out} !== {16'hBEEF, pat(old_pc)}) begin
      bad++; $display("FAIL jump_load: got pc=%h ir=%h want pc=BEEF ir=%h",
                      pc_out, ir_out, pat(old_pc));
    end
  endtask

  task automatic test_wrap_clear();
    drive(2'b11, 1'b0, 16'hFFFF, 1'b0);
    @(posedge clk); #1;
    e = sb.pop_front();
    total++;
    if (got !== e) begin
      bad++; $display("FAIL wrap_setup: got %h want %h", got, e);
    end
    drive(2'b01, 1'b1, 16'h0000, 1'b1);
    @(posedge clk); #1;
    e = sb.pop_front();
    total++;
    if (got !== e || pc_out !== 16'h0000 || icount_out !== 32'd0) begin
      bad++; $display("FAIL wrap_clear: got %h want %h (pc 0000 cnt 0)", got, e);
    end
  endtask

  task automatic test_counter_wrap();
    @(negedge clk);
    ps_in = 2'b00; il_in = 1'b0; icount_clr_in = 1'b0;
    force dut.r_icount = 32'hFFFF_FFFF;
    #1;
    release dut.r_icount;
    m.cnt = 32'hFFFF_FFFF;
    #1;
    total++;
    if (icount_out !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL cnt_preset: got %h want FFFFFFFF", icount_out);
    end
    drive(2'b00, 1'b1, 16'h0000, 1'b0);
    @(posedge clk); #1;
    e = sb.pop_front();
    total++;
    if (got !== e || icount_out !== 32'd0) begin
      bad++; $display("FAIL cnt_wrap: got %h want %h (cnt 0)", got, e);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 16'($urandom),
            1'($urandom_range(0, 7) == 0));
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (got !== e) begin
        bad++; $display("FAIL b2b[%0d]: got %h want %h", i, got, e);
      end
    end
  endtask

  task automatic test_mid_reset();
    drive(2'b10, 1'b1, 16'h0000, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    reset_model();
    total++;
    if (got !== st_t'({RST_PC, 16'h0000, 1'b0, 32'd0})) begin
      bad++; $display("FAIL midreset_async: got %h want pc=%h rest 0", got, RST_PC);
    end
    @(posedge clk); #1;
    total++;
    if (got !== st_t'({RST_PC, 16'h0000, 1'b0, 32'd0})) begin
      bad++; $display("FAIL midreset_hold: got %h want pc=%h rest 0", got, RST_PC);
    end
    @(negedge clk);
    ps_in = 2'b00; il_in = 1'b0; icount_clr_in = 1'b0;
    rst_n = 1'b1;
    drive(2'b01, 1'b1, 16'h0000, 1'b0);
    @(posedge clk); #1;
    e = sb.pop_front();
    total++;
    if (got !== e || ir_out !== 16'h1234 || pc_out !== 16'h0001) begin
      bad++; $display("FAIL midreset_restart: got %h want %h", got, e);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = pat(16'(i));
    mem[16'h0000] = 16'h1234;
    mem[16'h0010] = 16'h01C6;   // offset {111,110} = -2
    mem[16'hFFF0] = 16'h00C7;   // offset {011,111} = +31
    test_reset();
    test_fetch();
    test_branch();
    test_jump();
    test_wrap_clear();
    test_counter_wrap();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pc_ir
`default_nettype wire
